// File: rtl/alu_pkg.sv
// Shared ALU-stage definitions: function codes, multiplier FSM states and
// the default datapath width.
package alu_pkg;

  localparam int WIDTH_DEF = 32;

  // Function codes driven by the ALU control stage.
  localparam logic [5:0] MULTU   = 6'b011001;
  localparam logic [5:0] MFHI    = 6'b010000;
  localparam logic [5:0] MFLO    = 6'b010010;
  localparam logic [5:0] HILO_WR = 6'b111111;
  localparam logic [5:0] AND     = 6'b100100;
  localparam logic [5:0] OR      = 6'b100101;
  localparam logic [5:0] ADD     = 6'b100000;
  localparam logic [5:0] SUB     = 6'b100010;
  localparam logic [5:0] SLT     = 6'b101010;
  localparam logic [5:0] SLL     = 6'b000000;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

endpackage

// File: rtl/multu_hilo_if.sv
// Multiplier control bus between the ALU control stage (master) and the
// HI/LO multiplier (slave).
//   op/a/b             : function code and operands from the control stage
//   hi/lo              : committed HI/LO registers
//   rd_data            : MFHI/MFLO read result (combinational)
//   busy/done          : multiplier status
interface multu_hilo_if import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) ();
  logic [5:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;
  logic [WIDTH-1:0] rd_data;
  logic             busy;
  logic             done;

  modport master (output op, a, b, input hi, lo, rd_data, busy, done);
  modport slave  (input op, a, b, output hi, lo, rd_data, busy, done);
endinterface

// File: rtl/hilo_reg.sv
// HI/LO result register pair with MFHI/MFLO read mux.
//   clk, rst_n : clock, synchronous active-low clear
//   we_i       : load wdata_i into {hi,lo}
//   wdata_i    : 2*WIDTH product
//   op_i       : current function code, selects the read port
//   hi_o, lo_o : register contents
//   rd_data_o  : hi on MFHI, lo on MFLO, else 0
module hilo_reg import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               we_i,
  input  logic [2*WIDTH-1:0] wdata_i,
  input  logic [5:0]         op_i,
  output logic [WIDTH-1:0]   hi_o,
  output logic [WIDTH-1:0]   lo_o,
  output logic [WIDTH-1:0]   rd_data_o
);
  logic [2*WIDTH-1:0] hilo_q;

  always_ff @(posedge clk) begin
    if (!rst_n)    hilo_q <= '0;
    else if (we_i) hilo_q <= wdata_i;
  end

  assign hi_o = hilo_q[2*WIDTH-1:WIDTH];
  assign lo_o = hilo_q[WIDTH-1:0];

  always_comb begin
    rd_data_o = '0;
    if (op_i == MFHI)      rd_data_o = hi_o;
    else if (op_i == MFLO) rd_data_o = lo_o;
  end
endmodule

// File: rtl/multu_hilo.sv
// Sequential unsigned shift-add multiplier feeding the HI/LO registers.
// One multiplier bit is retired per clock; the product is committed to
// HI/LO on HILO_WR, which may arrive before the multiply finishes.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : slave side of the multiplier control bus
module multu_hilo import alu_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF,
  parameter int ITER  = WIDTH
) (
  input  logic         clk,
  input  logic         rst_n,
  multu_hilo_if.slave  bus
);
  localparam int CW = $clog2(ITER + 1);

  state_e             state_q, state_d;
  logic [5:0]         op_q;
  logic [WIDTH-1:0]   mcand_q;
  logic [2*WIDTH-1:0] prod_q, prod_step, commit_data;
  logic [CW-1:0]      count_q;
  logic               pend_q;
  logic [WIDTH:0]     sum;
  logic               start, hilo_wr, last, commit, busy, done;

  // Start fires on the first cycle of a MULTU run only.
  assign start   = (bus.op == MULTU) && (op_q != MULTU);
  assign hilo_wr = (bus.op == HILO_WR);
  assign last    = (count_q == CW'(ITER - 1));

  // Keep the add carry: it becomes the top bit after the right shift.
  assign sum       = {1'b0, prod_q[2*WIDTH-1:WIDTH]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
  assign prod_step = {sum, prod_q[WIDTH-1:1]};

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (start) state_d = RUN;
      RUN:  if (last)  state_d = (pend_q || hilo_wr) ? IDLE : DONE;
      DONE: if (start) state_d = RUN;
            else if (hilo_wr) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    busy        = (state_q == RUN);
    done        = (state_q == DONE);
    commit      = 1'b0;
    commit_data = prod_q;
    case (state_q)
      // Early HILO_WR: commit the final step's product directly, skipping DONE.
      RUN: if (last && (pend_q || hilo_wr)) begin
        commit      = 1'b1;
        commit_data = prod_step;
      end
      DONE: if (hilo_wr) commit = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      op_q    <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
      count_q <= '0;
      pend_q  <= 1'b0;
    end else begin
      op_q <= bus.op;
      if (start && state_q != RUN) begin
        mcand_q <= bus.a;
        prod_q  <= {{WIDTH{1'b0}}, bus.b};
        count_q <= '0;
        pend_q  <= 1'b0;
      end else if (state_q == RUN) begin
        prod_q  <= prod_step;
        count_q <= count_q + 1'b1;
        if (last)         pend_q <= 1'b0;
        else if (hilo_wr) pend_q <= 1'b1;
      end
    end
  end

  hilo_reg #(.WIDTH(WIDTH)) u_hilo (
    .clk       (clk),
    .rst_n     (rst_n),
    .we_i      (commit),
    .wdata_i   (commit_data),
    .op_i      (bus.op),
    .hi_o      (bus.hi),
    .lo_o      (bus.lo),
    .rd_data_o (bus.rd_data)
  );

  assign bus.busy = busy;
  assign bus.done = done;
endmodule

// File: doc/multu_hilo.md
# multu_hilo

Sequential 32×32 unsigned shift-add multiplier with the HI/LO result register pair, sitting directly downstream of the ALU control stage on its multiplier control bus. It consumes the registered 6-bit function code. It starts a multiply on MULTU and iterates one bit per clock for 32 clocks. On the control stage's HI/LO-write code (6'b111111) it commits the 64-bit product into HI/LO. It serves MFHI/MFLO reads to the result MUX.

## Interface
- `WIDTH`, default 32: operand width; product is 2·WIDTH.
- `ITER`, default WIDTH: iteration count per multiply.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: reset, synchronous and active-low.
- `op`, input, 6: function code from the control stage; MULTU=6'b011001, MFHI=6'b010000, MFLO=6'b010010, HILO_WR=6'b111111.
- `a`, input, WIDTH: multiplicand, sampled on the start cycle only.
- `b`, input, WIDTH: multiplier, sampled on the start cycle only.
- `hi`, output, WIDTH: HI register, the upper product half.
- `lo`, output, WIDTH: LO register, the lower product half.
- `rd_data`, output, WIDTH: combinational; `hi` when op==MFHI, `lo` when op==MFLO, else 0.
- `busy`, output, 1: high while in RUN.
- `done`, output, 1: high while in DONE; product valid internally, not yet committed.

## Operation
- States are IDLE, RUN and DONE.
- **Start.** `start` = (op==MULTU) && (op_q!=MULTU), where `op_q` is `op` registered.
  - Accepted in IDLE or DONE.
  - Ignored in RUN.
  - On start: mcand←a, prod←{0, b}, count←0, pend←0, go to RUN.
- **RUN step (per clock).** sum = prod[2W-1:W] + (prod[0] ? mcand : 0), held as a W+1-bit sum. Then prod ← {sum, prod[2W-1:1]} >> as a 2W+1→2W shift, i.e. prod ← {sum[W:0], prod[W-1:1]}. Then count ← count+1.
- **RUN exit.** After ITER steps (count==ITER-1 on the last step), go to DONE.
- **Commit.** op==HILO_WR in DONE: {hi,lo}←prod, go to IDLE.
- **Early HILO_WR.** op==HILO_WR seen in RUN sets sticky `pend`. Going RUN→DONE with pend=1 (or HILO_WR on that same final cycle) instead commits {hi,lo}←final product, clears pend, and goes to IDLE. No DONE cycle occurs.
- **HILO_WR in IDLE.** No effect; hi/lo unchanged.
- **op changing mid-RUN.** Non-MULTU codes do not abort; the multiply always completes.
- **Start in DONE without commit.** The uncommitted product is discarded; hi/lo keep their old value.
- **Read ports.** MFHI/MFLO read current hi/lo in any state; they are never blocked by RUN.
- **Arithmetic.** Unsigned only. The carry out of the W-bit add must be kept (W+1-bit sum); dropping it is a bug.

## Timing
- **Reset** (rst_n low at a rising edge), from any state including mid-RUN:
  - state←IDLE
  - hi=0, lo=0
  - prod, mcand, count, pend, op_q ← 0
  - busy=0, done=0
  - rd_data follows op combinationally, reading 0s.
- **Latency.** Start edge E0. RUN occupies edges E1..E32, with busy high from after E0 through E32. done is high after E32. Commit happens at the first edge with HILO_WR at or after E32 (or at E32 via pend). hi/lo are visible the cycle after the commit edge.
- **Upstream behaviour.** The control stage emits HILO_WR after counting 32 MULTU clocks, which can arrive before E32. The pend mechanism covers this; the bench must also accept HILO_WR arriving later.
- **Back-to-back.** MULTU→HILO_WR→MULTU produces a new start edge on the return to MULTU; the next multiply begins immediately after commit.
- **Outputs.** hi, lo, busy and done are registered. rd_data is combinational from op, hi and lo.

## Structure
- **Shared package `alu_pkg`:**
  - opcode constants MULTU, MFHI, MFLO, HILO_WR, plus AND/OR/ADD/SUB/SLT/SLL for the rest of the datapath
  - state enum {IDLE, RUN, DONE}
  - WIDTH default.
- **Sub-module `hilo_reg`:** 2·WIDTH register with synchronous active-low clear, write enable, and MFHI/MFLO read mux. The multiplier FSM/datapath stays in `multu_hilo`.

## Test plan
- **Basic multiply.** a=3, b=5, MULTU for 33 cycles, then HILO_WR for 1 cycle → hi=0, lo=15; busy high exactly 32 cycles.
- **Carry propagation.** a=b=32'hFFFFFFFF → hi=32'hFFFFFFFE, lo=32'h00000001. a=32'h80000000, b=2 → hi=1, lo=0.
- **Early HILO_WR.** HILO_WR pulsed at RUN cycle 31 (before completion) → commit on E32, no DONE cycle. A MFHI/MFLO read two cycles later returns the correct product.
- **Reset mid-RUN.** rst_n low at RUN cycle 10 → busy=0, hi=lo=0 next cycle. A fresh MULTU then gives the correct result.
- **Ignored codes.** MULTU held continuously during RUN does not restart. HILO_WR in IDLE leaves hi/lo unchanged. An ADD code mid-RUN does not abort.
- **Read mux.** After committing a=7, b=9: op=MFLO → rd_data=63; op=MFHI → rd_data=0; op=ADD → rd_data=0.
